// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default frame constants,
// common to uart_rx and uart_tx.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; reset value is chosen
// by the instantiating block so an idle line can reset to its idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Metastability filter: two back-to-back capture flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit qualification, mid-bit data sampling,
// stop-bit check, and a one-entry valid/ready output holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 I_baudrate_rx_clk,
  input  logic                 I_rxd,
  input  logic                 I_rx_ready,
  output logic                 O_baudrate_rx_clk_en,
  output logic [DATA_BITS-1:0] O_rx_data,
  output logic                 O_rx_valid,
  output logic                 O_frame_err,
  output logic                 O_overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 w_rxd;
  logic                 w_falling;
  logic                 r_rxd_prev;
  rx_state_e            r_state;
  logic [TW-1:0]        r_tick_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_en;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync_rxd (
    .clk (clk),
    .rst (rst),
    .i_d (I_rxd),
    .o_q (w_rxd)
  );

  assign w_falling = r_rxd_prev & ~w_rxd;

  // Receive FSM, counters, shift register and output register in one process.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxd_prev  <= 1'b1;
      r_state     <= IDLE;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_en        <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_rxd_prev  <= w_rxd;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      if (r_rx_valid && I_rx_ready) begin
        r_rx_valid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_falling) begin
            r_state    <= START;
            r_en       <= 1'b1;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
          end
        end
        START: begin
          if (I_baudrate_rx_clk) begin
            if (r_tick_cnt == TICK_HALF) begin
              r_tick_cnt <= '0;
              if (!w_rxd) begin
                r_state <= DATA;
              end else begin
                r_state <= IDLE;
                r_en    <= 1'b0;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (I_baudrate_rx_clk) begin
            if (r_tick_cnt == TICK_LAST) begin
              r_tick_cnt <= '0;
              r_shift    <= {w_rxd, r_shift[DATA_BITS-1:1]};
              r_bit_cnt  <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == BIT_LAST) begin
                r_state <= STOP;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (I_baudrate_rx_clk) begin
            if (r_tick_cnt == TICK_LAST) begin
              r_tick_cnt <= '0;
              if (w_rxd) begin
                r_state <= IDLE;
                r_en    <= 1'b0;
                // A same-cycle handshake frees the holding register for the new byte.
                if (!r_rx_valid || I_rx_ready) begin
                  r_rx_data  <= r_shift;
                  r_rx_valid <= 1'b1;
                end else begin
                  r_overrun <= 1'b1;
                end
              end else begin
                r_state     <= WAIT_HIGH;
                r_frame_err <= 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        WAIT_HIGH: begin
          if (w_rxd) begin
            r_state <= IDLE;
            r_en    <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_en    <= 1'b0;
        end
      endcase
    end
  end

  assign O_baudrate_rx_clk_en = r_en;
  assign O_rx_data            = r_rx_data;
  assign O_rx_valid           = r_rx_valid;
  assign O_frame_err          = r_frame_err;
  assign O_overrun            = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard testbench for uart_rx: frames are serialised by the bench, expected
// bytes and error events are queued at stimulus time and popped by a monitor.
module tb_uart_rx;

  localparam int OS       = 16;
  localparam int DB       = 8;
  localparam int TDIV     = 4;
  localparam int BIT_CLKS = OS * TDIV;
  localparam int DEL_TICK = OS / 2 + OS * DB + OS;
  localparam int EVT_FERR = 1;
  localparam int EVT_OVR  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic          rxd;
  logic          ready;
  logic          en;
  logic [DB-1:0] data;
  logic          valid;
  logic          ferr;
  logic          ovr;

  int            pcnt     = 0;
  int            n_checks = 0;
  int            n_errors = 0;
  logic [DB-1:0] exp_data_q[$];
  int            exp_evt_q[$];

  always #5 clk = ~clk;

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .I_baudrate_rx_clk    (tick),
    .I_rxd                (rxd),
    .I_rx_ready           (ready),
    .O_baudrate_rx_clk_en (en),
    .O_rx_data            (data),
    .O_rx_valid           (valid),
    .O_frame_err          (ferr),
    .O_overrun            (ovr)
  );

  // Posedge numbering; a tick is due on every posedge whose number is a multiple of TDIV.
  initial forever begin
    @(posedge clk);
    pcnt++;
  end

  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick = ((pcnt + 1) % TDIV == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_evt(input int code, input string name);
    if (exp_evt_q.size() == 0) check({name, "_unexpected"}, 32'(exp_evt_q.size()), 32'd1);
    else check(name, 32'(exp_evt_q.pop_front()), 32'(code));
  endtask

  // Monitor: sample half a cycle before the edge that acts on these values.
  initial forever begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (valid && ready) begin
        if (exp_data_q.size() == 0) check("rx_byte_unexpected", 32'(exp_data_q.size()), 32'd1);
        else check("rx_data", 32'(data), 32'(exp_data_q.pop_front()));
      end
      if (ferr) check_evt(EVT_FERR, "frame_err");
      if (ovr)  check_evt(EVT_OVR, "overrun");
    end
  end

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_en"},    32'(en),    32'd0);
    check({tag, "_data"},  32'(data),  32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_ferr"},  32'(ferr),  32'd0);
    check({tag, "_ovr"},   32'(ovr),   32'd0);
  endtask

  // Serialise start + data (LSB first) + stop. Optionally raise ready for exactly
  // the cycle of the stop-bit sample: 2 sync flops + 1 detect cycle, then DEL_TICK ticks.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit, input bit pulse_ready);
    logic [DB+1:0] bits;
    int s;
    int f;
    int p_del;
    bits  = {stop_bit, d, 1'b0};
    p_del = 0;
    for (int i = 0; i < (DB + 2) * BIT_CLKS; i++) begin
      @(negedge clk);
      if (i == 0) begin
        s     = pcnt;
        f     = ((s + 4 + TDIV - 1) / TDIV) * TDIV;
        p_del = f + TDIV * (DEL_TICK - 1);
      end
      rxd = bits[i / BIT_CLKS];
      if (pulse_ready) begin
        if (pcnt + 1 == p_del) ready = 1'b1;
        else if (pcnt == p_del) ready = 1'b0;
      end
    end
  endtask

  initial begin
    logic [DB-1:0] d;
    bit            bad_stop;
    rst   = 1'b1;
    rxd   = 1'b1;
    ready = 1'b1;
    repeat (4) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    idle(20);

    // Good frame with ready held high.
    exp_data_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(BIT_CLKS);
    check("a5_consumed", 32'(exp_data_q.size()), 32'd0);

    // Short low glitch: false start.
    rxd = 1'b0;
    repeat (4 * TDIV) @(negedge clk);
    check("glitch_en_high", 32'(en), 32'd1);
    idle(BIT_CLKS);
    check("glitch_en_low", 32'(en), 32'd0);
    check("glitch_no_valid", 32'(valid), 32'd0);

    // Bad stop bit followed by a 3-bit-time break.
    exp_evt_q.push_back(EVT_FERR);
    send_frame(8'h3C, 1'b0, 1'b0);
    rxd = 1'b0;
    repeat (3 * BIT_CLKS) @(negedge clk);
    check("ferr_no_valid", 32'(valid), 32'd0);
    idle(BIT_CLKS);
    check("ferr_single", 32'(exp_evt_q.size()), 32'd0);
    check("ferr_en_low", 32'(en), 32'd0);

    // Overrun: two bytes with nobody consuming.
    ready = 1'b0;
    exp_data_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0);
    idle(BIT_CLKS / 2);
    exp_evt_q.push_back(EVT_OVR);
    send_frame(8'h22, 1'b1, 1'b0);
    idle(BIT_CLKS / 2);
    check("ovr_data_kept", 32'(data), 32'h11);
    check("ovr_valid_kept", 32'(valid), 32'd1);
    check("ovr_seen", 32'(exp_evt_q.size()), 32'd0);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
    check("ovr_valid_cleared", 32'(valid), 32'd0);

    // Handshake on the exact delivery cycle.
    exp_data_q.push_back(8'h33);
    send_frame(8'h33, 1'b1, 1'b0);
    idle(BIT_CLKS / 2);
    exp_data_q.push_back(8'h22);
    send_frame(8'h22, 1'b1, 1'b1);
    idle(4);
    check("same_cycle_data", 32'(data), 32'h22);
    check("same_cycle_valid", 32'(valid), 32'd1);
    check("same_cycle_old_taken", 32'(exp_data_q.size()), 32'd1);
    ready = 1'b1;
    idle(8);
    check("same_cycle_drained", 32'(exp_data_q.size()), 32'd0);

    // Reset in the middle of 0xFF after bit 3, then a clean frame.
    rxd = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    rxd = 1'b1;
    repeat (4 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("mid_rst");
    rst = 1'b0;
    idle(BIT_CLKS);
    check("post_rst_en", 32'(en), 32'd0);
    exp_data_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(BIT_CLKS);
    check("post_rst_5a", 32'(exp_data_q.size()), 32'd0);

    // Random frames: random data, consumer latency, gaps and occasional bad stop bits.
    for (int k = 0; k < 16; k++) begin
      d        = DB'($urandom_range(0, 255));
      bad_stop = ($urandom_range(0, 3) == 0);
      ready    = 1'($urandom_range(0, 1));
      if (bad_stop) exp_evt_q.push_back(EVT_FERR);
      else exp_data_q.push_back(d);
      send_frame(d, !bad_stop, 1'b0);
      ready = 1'b1;
      idle($urandom_range(4, 100));
    end
    idle(BIT_CLKS);

    check("final_data_q_empty", 32'(exp_data_q.size()), 32'd0);
    check("final_evt_q_empty", 32'(exp_evt_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16, baud ticks per bit period; SHALL be an even value from 8 to 32.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; SHALL be a value from 5 to 8.
REQ-003 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 I_baudrate_rx_clk  input  1  one-clk-wide oversample tick from baudrate_gen, OVERSAMPLE ticks per bit.
REQ-006 I_rxd  input  1  asynchronous serial line, idle high.
REQ-007 I_rx_ready  input  1  consumer accepts O_rx_data on a cycle where O_rx_valid is high.
REQ-008 O_baudrate_rx_clk_en  output  1  enable to baudrate_gen I_baudrate_rx_clk_en.
REQ-009 O_rx_data  output  DATA_BITS  received byte, LSB = first bit on the line.
REQ-010 O_rx_valid  output  1  O_rx_data holds an unconsumed byte.
REQ-011 O_frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-012 O_overrun  output  1  one-clk pulse: byte completed while the previous byte was unconsumed.

Function
REQ-013 I_rxd SHALL pass through a 2-flop synchronizer before any use; detection latency is 2 clk.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-015 IDLE: a synchronized falling edge (previous 1, current 0) SHALL go to START and clear the tick and bit counters.
REQ-016 O_baudrate_rx_clk_en SHALL be high in every state except IDLE.
REQ-017 START: after OVERSAMPLE/2 ticks, a low line SHALL go to DATA with the tick counter cleared; a high line SHALL return to IDLE with no outputs asserted (false start).
REQ-018 DATA: each bit SHALL be sampled on the OVERSAMPLE-th tick after the previous sample, which is mid-bit, and shifted in LSB-first.
REQ-019 DATA: after DATA_BITS samples, the FSM SHALL go to STOP.
REQ-020 STOP: after OVERSAMPLE ticks, a high sample SHALL deliver the byte and go to IDLE.
REQ-021 STOP: after OVERSAMPLE ticks, a low sample SHALL pulse O_frame_err, discard the byte and go to WAIT_HIGH.
REQ-022 WAIT_HIGH: the FSM SHALL remain until the synchronized line is 1, then go to IDLE, so that a break produces a single error.
REQ-023 Delivery: O_rx_data SHALL update and O_rx_valid SHALL set on the clk after the stop-bit sample.
REQ-024 O_rx_valid SHALL clear on the clk after a cycle where O_rx_valid and I_rx_ready are both high.
REQ-025 O_rx_data SHALL be stable while O_rx_valid is high.
REQ-026 Delivery while O_rx_valid=1 and I_rx_ready=0: O_overrun SHALL pulse, the new byte SHALL be dropped, and the old data and valid SHALL be kept.
REQ-027 Delivery in the same cycle as a handshake (valid=1, ready=1): the new byte SHALL load, O_rx_valid SHALL stay 1, and there SHALL be no overrun.
REQ-028 Ticks arriving in IDLE SHALL be ignored.
REQ-029 The tick counter SHALL be $clog2(OVERSAMPLE) bits wide and wrap to 0 at OVERSAMPLE-1.

Reset
REQ-030 rst SHALL put the FSM in IDLE and zero the counters and the shift register.
REQ-031 Outputs under rst: O_rx_data=0, O_rx_valid=0, O_frame_err=0, O_overrun=0, O_baudrate_rx_clk_en=0.
REQ-032 Synchronizer flops SHALL reset to 1 (idle line), so that reset release never fakes a start bit.
REQ-033 rst mid-frame SHALL abandon the frame with no error pulse; the next falling edge starts a fresh frame.

Structure
REQ-034 Package uart_pkg SHALL hold the FSM state enum and the default constants OVERSAMPLE=16 and DATA_BITS=8, shared with uart_tx.
REQ-035 The synchronizer SHALL be sub-module sync_2ff (reset value parameterized), reused elsewhere in the UART.

Verification
REQ-036 Send frame 0xA5 with a good stop bit, I_rx_ready=1 -> one valid cycle, O_rx_data=0xA5, no error pulses.
REQ-037 Low glitch of 4 ticks in IDLE -> return to IDLE, O_rx_valid stays 0, enable drops after the START check.
REQ-038 Frame 0x3C with stop bit low -> O_frame_err pulses once, O_rx_valid stays 0, line held low 3 bit-times yields no further error.
REQ-039 Frames 0x11 then 0x22 with I_rx_ready=0 -> O_overrun pulses once, O_rx_data stays 0x11; then ready=1 -> valid clears.
REQ-040 I_rx_ready asserted on the exact cycle 0x22 completes -> O_rx_data=0x22, valid stays high, no overrun.
REQ-041 rst asserted after bit 3 of 0xFF, then frame 0x5A -> all outputs 0 during rst, then O_rx_data=0x5A, no frame error.
